// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver/transmitter state encoding,
//               default bit timing and counter sizing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 100 MHz system clock / 9600 baud
  localparam int unsigned c_CLKS_PER_BIT_DEFAULT = 10417;

  // Data bits per frame (8N1)
  localparam int unsigned c_DATA_BITS = 8;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_state_e;

  // Bits needed to hold 0 .. clks-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Consumer-side handshake of the UART receiver: received byte,
//               valid/acknowledge pair, sticky error flags and busy status.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
  import uart_pkg::*;

  logic                   rx_ack;
  logic [c_DATA_BITS-1:0] rx_data;
  logic                   rx_valid;
  logic                   ferr;
  logic                   overrun;
  logic                   busy;

  // Receiver side: produces data and status, consumes the acknowledge
  modport master (
    input  rx_ack,
    output rx_data,
    output rx_valid,
    output ferr,
    output overrun,
    output busy
  );

  // Consumer side: reads data and status, produces the acknowledge
  modport slave (
    output rx_ack,
    input  rx_data,
    input  rx_valid,
    input  ferr,
    input  overrun,
    input  busy
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Single-bit two-flop synchronizer with asynchronous,
//               active-high reset to a programmable value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input to settle metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Samples the synchronized line at mid-bit,
//               shifts data LSB first, checks the stop bit and presents the
//               byte with a valid/ack handshake plus sticky framing-error and
//               overrun flags. A low stop bit parks the receiver until the
//               line returns high so a break is not taken as a new frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
  input  wire        clk,
  input  wire        resetk,
  input  wire        RX,
  uart_rx_if.master  bus
);

  localparam int unsigned             c_CNT_W     = cnt_width(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0]      c_BIT_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0]      c_HALF_LAST = c_CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [2:0]              c_LAST_IDX  = 3'(c_DATA_BITS - 1);

  // Synchronized serial line and its one-cycle-old copy for edge detection
  logic                   rx_sync;
  logic                   rx_prev_q;

  uart_state_e            state_q;
  logic [c_CNT_W-1:0]     cnt_q;
  logic [2:0]             bit_idx_q;
  logic [c_DATA_BITS-1:0] shift_q;

  logic [c_DATA_BITS-1:0] rx_data_q;
  logic                   rx_valid_q;
  logic                   ferr_q;
  logic                   overrun_q;

  logic                   fall_d;
  logic                   bit_done_d;
  logic                   half_done_d;
  logic [c_DATA_BITS-1:0] shift_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (resetk),
    .d_i (RX),
    .q_o (rx_sync)
  );

  // Start-edge detect, bit-period terminal counts and next shift value
  assign fall_d      = rx_prev_q & ~rx_sync;
  assign bit_done_d  = (cnt_q == c_BIT_LAST);
  assign half_done_d = (cnt_q == c_HALF_LAST);
  assign shift_d     = {rx_sync, shift_q[c_DATA_BITS-1:1]};

  // Frame state machine with registered data, handshake and error flags
  always_ff @(posedge clk or posedge resetk) begin
    if (resetk) begin
      rx_prev_q  <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rx_prev_q <= rx_sync;

      // Acknowledge clears the flags; frame events below may override
      if (bus.rx_ack) begin
        rx_valid_q <= 1'b0;
        ferr_q     <= 1'b0;
        overrun_q  <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (fall_d) begin
            state_q   <= START;
            cnt_q     <= '0;
            bit_idx_q <= '0;
          end
        end

        // Re-check the line at the middle of the start bit to reject glitches
        START: begin
          if (half_done_d) begin
            cnt_q   <= '0;
            state_q <= rx_sync ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (bit_done_d) begin
            cnt_q     <= '0;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == c_LAST_IDX) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (bit_done_d) begin
            cnt_q <= '0;
            if (rx_sync) begin
              // New byte wins over a coincident acknowledge for rx_valid;
              // overrun only when the old byte was still unread and unacked
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              if (rx_valid_q && !bus.rx_ack) begin
                overrun_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        // Hold off through a break until the line idles high again
        WAIT_HIGH: begin
          if (rx_sync) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.ferr     = ferr_q;
  assign bus.overrun  = overrun_q;
  assign bus.busy     = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx at 16 clocks per bit.
//               Stimulus pushes the expected byte / framing-error events into
//               a scoreboard queue; a negedge monitor pops and compares each
//               time the receiver presents a new byte or raises ferr.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int c_CLKS  = 16;
  localparam int c_FRAME = 10 * c_CLKS;

  typedef struct packed {
    logic       kind;   // 0: byte presented, 1: framing error raised
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       ovr;
  } exp_t;

  logic clk;
  logic resetk;
  logic rx;

  int n_checks = 0;
  int n_errors = 0;

  exp_t sb_q[$];

  logic       prev_valid = 1'b0;
  logic       prev_ferr  = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (c_CLKS)
  ) u_dut (
    .clk    (clk),
    .resetk (resetk),
    .RX     (rx),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic kind, input logic [7:0] data,
                          input logic valid, input logic ferr, input logic ovr);
    exp_t e;
    e.kind  = kind;
    e.data  = data;
    e.valid = valid;
    e.ferr  = ferr;
    e.ovr   = ovr;
    sb_q.push_back(e);
  endtask

  task automatic score_event(input logic kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event kind=%0d data=0x%0h valid=%0d ferr=%0d ovr=%0d",
               kind, bus.rx_data, bus.rx_valid, bus.ferr, bus.overrun);
    end else begin
      e = sb_q.pop_front();
      check("evt_kind",    32'(kind),         32'(e.kind));
      check("evt_data",    32'(bus.rx_data),  32'(e.data));
      check("evt_valid",   32'(bus.rx_valid), 32'(e.valid));
      check("evt_ferr",    32'(bus.ferr),     32'(e.ferr));
      check("evt_overrun", 32'(bus.overrun),  32'(e.ovr));
    end
  endtask

  // Monitor: new byte (valid rise or data change while valid) or ferr rise
  always @(negedge clk) begin
    if (!resetk) begin
      if (bus.ferr && !prev_ferr) begin
        score_event(1'b1);
      end
      if (bus.rx_valid && (!prev_valid || (bus.rx_data != prev_data))) begin
        score_event(1'b0);
      end
    end
    prev_valid <= bus.rx_valid;
    prev_ferr  <= bus.ferr;
    prev_data  <= bus.rx_data;
  end

  // Drives ncyc clocks of a frame (start, 8 data LSB first, stop);
  // rx_ack is high only during cycle ack_cyc of the frame (-1: never)
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input int ack_cyc, input int ncyc);
    logic [9:0] bits;
    bits = {stop, data, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      rx         = bits[c / c_CLKS];
      bus.rx_ack = (c == ack_cyc);
      @(posedge clk);
      #1;
    end
    bus.rx_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetk     = 1'b1;
    rx         = 1'b1;
    bus.rx_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",    32'(bus.rx_data),  32'h00);
    check("rst_valid",   32'(bus.rx_valid), 32'h0);
    check("rst_ferr",    32'(bus.ferr),     32'h0);
    check("rst_overrun", 32'(bus.overrun),  32'h0);
    check("rst_busy",    32'(bus.busy),     32'h0);
    resetk = 1'b0;
    idle(5);

    // Good frame 0xA5, held until acknowledged
    push_exp(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, -1, c_FRAME);
    idle(10);
    check("a5_hold_valid", 32'(bus.rx_valid), 32'h1);
    check("a5_hold_data",  32'(bus.rx_data),  32'hA5);
    ack_pulse();
    check("a5_ack_valid",   32'(bus.rx_valid), 32'h0);
    check("a5_ack_ferr",    32'(bus.ferr),     32'h0);
    check("a5_ack_overrun", 32'(bus.overrun),  32'h0);

    // Short low glitch: busy rises, then back to idle with no flags
    rx = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
    check("glitch_busy_hi", 32'(bus.busy), 32'h1);
    idle(20);
    check("glitch_busy_lo", 32'(bus.busy),     32'h0);
    check("glitch_valid",   32'(bus.rx_valid), 32'h0);
    check("glitch_ferr",    32'(bus.ferr),     32'h0);
    check("glitch_overrun", 32'(bus.overrun),  32'h0);

    // Bad stop on 0x3C, then a good 0x55 with ferr still sticky
    push_exp(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, -1, c_FRAME);
    idle(20);
    check("ferr_set",   32'(bus.ferr),     32'h1);
    check("ferr_valid", 32'(bus.rx_valid), 32'h0);
    check("ferr_busy",  32'(bus.busy),     32'h0);
    push_exp(1'b0, 8'h55, 1'b1, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, -1, c_FRAME);
    idle(10);
    check("x55_data",  32'(bus.rx_data),  32'h55);
    check("x55_valid", 32'(bus.rx_valid), 32'h1);
    ack_pulse();
    check("x55_ack_ferr",  32'(bus.ferr),     32'h0);
    check("x55_ack_valid", 32'(bus.rx_valid), 32'h0);

    // Overrun: 0x11 then 0x22 without acknowledge
    push_exp(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, -1, c_FRAME);
    idle(10);
    push_exp(1'b0, 8'h22, 1'b1, 1'b0, 1'b1);
    send_frame(8'h22, 1'b1, -1, c_FRAME);
    idle(10);
    check("ovr_data",    32'(bus.rx_data),  32'h22);
    check("ovr_valid",   32'(bus.rx_valid), 32'h1);
    check("ovr_overrun", 32'(bus.overrun),  32'h1);
    ack_pulse();
    check("ovr_ack_valid",   32'(bus.rx_valid), 32'h0);
    check("ovr_ack_ferr",    32'(bus.ferr),     32'h0);
    check("ovr_ack_overrun", 32'(bus.overrun),  32'h0);

    // Acknowledge in the very cycle the second byte loads (stop sample at
    // clock 155 of the frame: 2 sync + 1 edge + 8 half-bit + 9*16)
    push_exp(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, -1, c_FRAME);
    idle(10);
    push_exp(1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 154, c_FRAME);
    check("coinc_data",    32'(bus.rx_data),  32'h22);
    check("coinc_valid",   32'(bus.rx_valid), 32'h1);
    check("coinc_overrun", 32'(bus.overrun),  32'h0);

    // Reset in the middle of the 4th data bit, then a clean 0x7E
    send_frame(8'h99, 1'b1, -1, 4 * c_CLKS + c_CLKS / 2);
    resetk = 1'b1;
    rx     = 1'b1;
    #2;
    check("mid_rst_data",    32'(bus.rx_data),  32'h00);
    check("mid_rst_valid",   32'(bus.rx_valid), 32'h0);
    check("mid_rst_ferr",    32'(bus.ferr),     32'h0);
    check("mid_rst_overrun", 32'(bus.overrun),  32'h0);
    check("mid_rst_busy",    32'(bus.busy),     32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetk = 1'b0;
    idle(10);
    push_exp(1'b0, 8'h7E, 1'b1, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, -1, c_FRAME);
    idle(10);
    check("x7e_data",    32'(bus.rx_data),  32'h7E);
    check("x7e_valid",   32'(bus.rx_valid), 32'h1);
    check("x7e_ferr",    32'(bus.ferr),     32'h0);
    check("x7e_overrun", 32'(bus.overrun),  32'h0);
    ack_pulse();
    idle(4);

    check("sb_left_over", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
